zeroriscy_xbar_nxm: RTL and testbench
=====================================

// Module: zeroriscy_xbar_nxm
// PURPOSE
//  Parametrised NM-master x NS-slave crossbar for the zeroriscy subsystem; generalises the fixed 2x3 xbar.
//  Masters speak req/gnt/rvalid; slaves are single-cycle SRAM-style (rdata/err valid the cycle after req).
//  Decodes address to slave via base/mask table; per-slave arbitration; unmapped addresses get a decode error.
//  Sits between core instr/data ports (plus any future DMA/debug master) and SRAMs/system bus.
// PARAMETERS
//  NM        2                 number of masters
//  NS        3                 number of slaves
//  AW        32                address width
//  DW        32                data width (BE width = DW/8)
//  ARB_RR    1                 1: round-robin per slave; 0: fixed priority, lowest master index wins
//  SLV_BASE  {32'h8000_0000..} NS x AW packed; slave s matches when (addr & SLV_MASK[s]) == SLV_BASE[s]
//  SLV_MASK  {32'hFFFF_0000..} NS x AW packed; lowest matching s wins on overlap
// PORTS
//  clk        in   1        clock
//  reset      in   1        synchronous, active-high reset
//  m_req      in   NM       master request
//  m_gnt      out  NM       request accepted this cycle
//  m_rvalid   out  NM       response valid (cycle after gnt)
//  m_we       in   NM       write enable
//  m_be       in   NM*DW/8  byte enables
//  m_addr     in   NM*AW    address
//  m_wdata    in   NM*DW    write data
//  m_rdata    out  NM*DW    read data, qualified by m_rvalid
//  m_err      out  NM       error, qualified by m_rvalid
//  s_req      out  NS       slave request (one-cycle pulse per transfer)
//  s_we       out  NS       write enable
//  s_be       out  NS*DW/8  byte enables
//  s_addr     out  NS*AW    address (full, unmodified)
//  s_wdata    out  NS*DW    write data
//  s_rdata    in   NS*DW    read data, valid cycle after s_req
//  s_err      in   NS       error, valid cycle after s_req
// BEHAVIOUR
//  - Reset: m_rvalid=0, m_err=0, m_rdata=0, response regs cleared, RR pointers=0; outstanding responses dropped.
//  - Decode (comb): per master, slave index or DECERR. Request path is combinational: m_gnt/s_req same cycle.
//  - Arbitration per slave among masters decoding to it: RR: priority starts at ptr, ptr<=winner+1 (mod NM)
//    on grant; no request -> ptr holds. ARB_RR=0: lowest index wins, no state.
//  - Winner: m_gnt=1, s_req=1, s_we/be/addr/wdata = winner's. Losers: m_gnt=0; master holds req/addr stable.
//  - Idle slaves: s_req=0, other s_* outputs 0.
//  - DECERR: m_gnt=1 same cycle, no s_req; next cycle m_rvalid=1, m_err=1, m_rdata=0. Independent per master.
//  - Response: registered {valid, slave idx, decerr} per master; next cycle m_rvalid=1, rdata/err muxed
//    from recorded slave. Latency req->rvalid = 1 cycle, for reads and writes.
//  - Back-to-back: master may issue new req in same cycle as rvalid; throughput 1/cycle/master when uncontended.
//  - Distinct masters to distinct slaves proceed in parallel same cycle.
//  - m_gnt never asserted without m_req; at most one master granted per slave per cycle.
// STRUCTURE
//  - zeroriscy_xbar_pkg: DECERR encoding, slave-index typedef (clog2(NS)+1 bits), default base/mask map.
//  - Sub-module zeroriscy_rr_arbiter (N requesters, RR/fixed mode, onehot grant, ptr state); one per slave.
//  - Top: decode, NS arbiter instances, request mux, per-master response register + rdata/err mux.
// TESTING
//  - Reset: assert reset 3 cycles with m_req=1 -> m_gnt/s_req follow comb, m_rvalid=0 throughout, ptrs 0.
//  - Single read: m0 req addr 32'h8000_0010 -> same-cycle gnt, s_req[0], next cycle rvalid, rdata=s_rdata[0].
//  - Contention RR: m0,m1 both hold req to slave 0 for 4 cycles -> grants m0,m1,m0,m1; ARB_RR=0 -> m0 always.
//  - Parallel: m0->slave0, m1->slave1 same cycle -> both gnt, both rvalid next cycle, correct rdata each.
//  - Unmapped: m1 addr 32'h4000_0000 -> gnt, no s_req, next cycle rvalid, err=1, rdata=0.
//  - Slave err + back-to-back: s_err[2]=1 on write then immediate read -> err=1 then err=0, 1/cycle.

Source files
------------

// File: rtl/zeroriscy_xbar_pkg.sv
// Shared types and the default address map for the zeroriscy NxM crossbar.
// Slave indices carry one spare bit so the all-ones code can flag a decode error.
package zeroriscy_xbar_pkg;

  localparam int MAX_NS = 16;
  localparam int SIDX_W = $clog2(MAX_NS) + 1;

  typedef logic [SIDX_W-1:0] sidx_t;

  localparam sidx_t DECERR = '1;

  // Default map: three 64 KiB windows starting at 0x8000_0000.
  localparam int DEF_NS = 3;
  localparam logic [DEF_NS*32-1:0] DEF_SLV_BASE = {32'h8002_0000, 32'h8001_0000, 32'h8000_0000};
  localparam logic [DEF_NS*32-1:0] DEF_SLV_MASK = {3{32'hFFFF_0000}};

endpackage

// File: rtl/zeroriscy_rr_arbiter.sv
// Per-slave arbiter: one-hot grant among N requesters, round-robin or fixed priority.
// In round-robin mode the pointer names the requester with highest priority next cycle.
module zeroriscy_rr_arbiter #(
  parameter int N  = 2,
  parameter bit RR = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  int            rank;
  int            best;
  int            win;

  // Lowest rank wins; rank is distance from the pointer (RR) or the plain index (fixed).
  always_comb begin
    rank = 0;
    best = N;
    win  = 0;
    gnt  = '0;
    for (int i = 0; i < N; i++) begin
      rank = RR ? ((i + N - int'(ptr)) % N) : i;
      if (req[i] && (rank < best)) begin
        best = rank;
        win  = i;
      end
    end
    for (int i = 0; i < N; i++) begin
      gnt[i] = (best < N) && (win == i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (RR && (|req)) begin
      ptr <= PW'((win + 1) % N);
    end
  end

endmodule

// File: rtl/zeroriscy_xbar_nxm.sv
// NM-master x NS-slave crossbar: combinational decode/arbitration/request mux,
// registered per-master response tracking with a one-cycle read/write latency.
module zeroriscy_xbar_nxm
  import zeroriscy_xbar_pkg::*;
#(
  parameter int                NM       = 2,
  parameter int                NS       = 3,
  parameter int                AW       = 32,
  parameter int                DW       = 32,
  parameter bit                ARB_RR   = 1'b1,
  parameter logic [NS*AW-1:0]  SLV_BASE = DEF_SLV_BASE,
  parameter logic [NS*AW-1:0]  SLV_MASK = DEF_SLV_MASK
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NM-1:0]        m_req,
  output logic [NM-1:0]        m_gnt,
  output logic [NM-1:0]        m_rvalid,
  input  logic [NM-1:0]        m_we,
  input  logic [NM*DW/8-1:0]   m_be,
  input  logic [NM*AW-1:0]     m_addr,
  input  logic [NM*DW-1:0]     m_wdata,
  output logic [NM*DW-1:0]     m_rdata,
  output logic [NM-1:0]        m_err,
  output logic [NS-1:0]        s_req,
  output logic [NS-1:0]        s_we,
  output logic [NS*DW/8-1:0]   s_be,
  output logic [NS*AW-1:0]     s_addr,
  output logic [NS*DW-1:0]     s_wdata,
  input  logic [NS*DW-1:0]     s_rdata,
  input  logic [NS-1:0]        s_err
);

  localparam int BW = DW / 8;

  sidx_t         m_sidx   [NM];
  logic [NM-1:0] m_dec;
  logic [NM-1:0] arb_req  [NS];
  logic [NM-1:0] arb_gnt  [NS];
  logic [NM-1:0] rsp_valid;
  logic [NM-1:0] rsp_dec;
  sidx_t         rsp_sidx [NM];

  // Descending scan so the lowest matching slave wins on overlapping windows.
  always_comb begin
    m_dec = '0;
    for (int m = 0; m < NM; m++) begin
      m_sidx[m] = DECERR;
      for (int s = NS - 1; s >= 0; s--) begin
        if ((m_addr[m*AW +: AW] & SLV_MASK[s*AW +: AW]) == SLV_BASE[s*AW +: AW]) begin
          m_sidx[m] = sidx_t'(s);
        end
      end
      m_dec[m] = m_req[m] && (m_sidx[m] == DECERR);
    end
  end

  always_comb begin
    for (int s = 0; s < NS; s++) begin
      arb_req[s] = '0;
      for (int m = 0; m < NM; m++) begin
        arb_req[s][m] = m_req[m] && (m_sidx[m] == sidx_t'(s));
      end
    end
  end

  for (genvar gs = 0; gs < NS; gs++) begin : g_arb
    zeroriscy_rr_arbiter #(
      .N  (NM),
      .RR (ARB_RR)
    ) u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (arb_req[gs]),
      .gnt   (arb_gnt[gs])
    );
  end

  // Decode errors are accepted immediately; mapped requests only when their arbiter picks them.
  always_comb begin
    m_gnt   = m_dec;
    s_req   = '0;
    s_we    = '0;
    s_be    = '0;
    s_addr  = '0;
    s_wdata = '0;
    for (int s = 0; s < NS; s++) begin
      for (int m = 0; m < NM; m++) begin
        if (arb_gnt[s][m]) begin
          m_gnt[m]              = 1'b1;
          s_req[s]              = 1'b1;
          s_we[s]               = m_we[m];
          s_be[s*BW +: BW]      = m_be[m*BW +: BW];
          s_addr[s*AW +: AW]    = m_addr[m*AW +: AW];
          s_wdata[s*DW +: DW]   = m_wdata[m*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_dec   <= '0;
      for (int m = 0; m < NM; m++) begin
        rsp_sidx[m] <= '0;
      end
    end else begin
      rsp_valid <= m_gnt;
      rsp_dec   <= m_dec;
      for (int m = 0; m < NM; m++) begin
        rsp_sidx[m] <= m_sidx[m];
      end
    end
  end

  assign m_rvalid = rsp_valid;

  // Response data is forced to zero whenever no response is pending.
  always_comb begin
    m_rdata = '0;
    m_err   = '0;
    for (int m = 0; m < NM; m++) begin
      if (rsp_valid[m]) begin
        if (rsp_dec[m]) begin
          m_err[m] = 1'b1;
        end else begin
          for (int s = 0; s < NS; s++) begin
            if (rsp_sidx[m] == sidx_t'(s)) begin
              m_rdata[m*DW +: DW] = s_rdata[s*DW +: DW];
              m_err[m]            = s_err[s];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_zeroriscy_xbar_nxm.sv
// Testbench for zeroriscy_xbar_nxm: directed scenarios plus a randomized run checked
// against an address-range / least-recently-granted reference model (RR and fixed-priority DUTs).
module tb_zeroriscy_xbar_nxm;

  localparam int NM = 2;
  localparam int NS = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic               clk = 1'b0;
  logic               reset;
  logic [NM-1:0]      m_req;
  logic [NM-1:0]      m_we;
  logic [NM*BW-1:0]   m_be;
  logic [NM*AW-1:0]   m_addr;
  logic [NM*DW-1:0]   m_wdata;
  logic [NS*DW-1:0]   s_rdata;
  logic [NS-1:0]      s_err;

  logic [NM-1:0]      m_gnt, m_rvalid, m_err;
  logic [NM*DW-1:0]   m_rdata;
  logic [NS-1:0]      s_req, s_we;
  logic [NS*BW-1:0]   s_be;
  logic [NS*AW-1:0]   s_addr;
  logic [NS*DW-1:0]   s_wdata;

  logic [NM-1:0]      fp_m_gnt, fp_m_rvalid, fp_m_err;
  logic [NM*DW-1:0]   fp_m_rdata;
  logic [NS-1:0]      fp_s_req, fp_s_we;
  logic [NS*BW-1:0]   fp_s_be;
  logic [NS*AW-1:0]   fp_s_addr;
  logic [NS*DW-1:0]   fp_s_wdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  zeroriscy_xbar_nxm #(.NM(NM), .NS(NS), .AW(AW), .DW(DW), .ARB_RR(1'b1)) dut (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_we(m_we), .m_be(m_be),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_err(m_err),
    .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_err(s_err)
  );

  zeroriscy_xbar_nxm #(.NM(NM), .NS(NS), .AW(AW), .DW(DW), .ARB_RR(1'b0)) dut_fp (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_gnt(fp_m_gnt), .m_rvalid(fp_m_rvalid), .m_we(m_we), .m_be(m_be),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(fp_m_rdata), .m_err(fp_m_err),
    .s_req(fp_s_req), .s_we(fp_s_we), .s_be(fp_s_be), .s_addr(fp_s_addr), .s_wdata(fp_s_wdata),
    .s_rdata(s_rdata), .s_err(s_err)
  );

  // Slave s owns the 64 KiB window 0x8000_0000 + s*0x1_0000; anything else is unmapped.
  function automatic int ref_decode(logic [31:0] a);
    int hi;
    hi = int'(a[31:16]);
    if (hi >= 'h8000 && hi < 'h8000 + NS) return hi - 'h8000;
    return -1;
  endfunction

  task automatic set_master(int m, bit req, bit we, logic [31:0] addr, logic [31:0] wdata, logic [3:0] be);
    m_req[m]            = req;
    m_we[m]             = we;
    m_addr[m*AW +: AW]  = addr;
    m_wdata[m*DW +: DW] = wdata;
    m_be[m*BW +: BW]    = be;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    m_req = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_master(0, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'hF);
    set_master(1, 1'b1, 1'b0, 32'h8001_0000, 32'h0, 4'hF);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++; if (m_gnt !== 2'b11) begin n_err++; $display("[TB] FAIL reset_gnt: got %b exp 11", m_gnt); end
      n_vec++; if (s_req !== 3'b011) begin n_err++; $display("[TB] FAIL reset_sreq: got %b exp 011", s_req); end
      n_vec++; if (m_rvalid !== 2'b00) begin n_err++; $display("[TB] FAIL reset_rvalid: got %b exp 00", m_rvalid); end
      n_vec++; if (fp_m_rvalid !== 2'b00) begin n_err++; $display("[TB] FAIL reset_fp_rvalid: got %b exp 00", fp_m_rvalid); end
      step();
    end
    reset = 1'b0;
    m_req = '0;
    #1;
    n_vec++; if (m_gnt !== 2'b00) begin n_err++; $display("[TB] FAIL idle_gnt: got %b exp 00", m_gnt); end
    n_vec++; if (s_addr !== '0) begin n_err++; $display("[TB] FAIL idle_saddr: got %h exp 0", s_addr); end
    step();
    #1;
    n_vec++; if (m_rvalid !== 2'b00) begin n_err++; $display("[TB] FAIL post_reset_rvalid: got %b exp 00", m_rvalid); end
    n_vec++; if (m_rdata !== '0) begin n_err++; $display("[TB] FAIL post_reset_rdata: got %h exp 0", m_rdata); end
  endtask

  task automatic test_single_read();
    logic [31:0] d;
    d = $urandom;
    set_master(0, 1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'hF);
    #1;
    n_vec++; if (m_gnt !== 2'b01) begin n_err++; $display("[TB] FAIL single_gnt: got %b exp 01", m_gnt); end
    n_vec++; if (s_req !== 3'b001) begin n_err++; $display("[TB] FAIL single_sreq: got %b exp 001", s_req); end
    n_vec++; if (s_addr[0 +: AW] !== 32'h8000_0010) begin n_err++; $display("[TB] FAIL single_saddr: got %h exp 80000010", s_addr[0 +: AW]); end
    step();
    m_req = '0;
    s_rdata[0 +: DW] = d;
    s_err = '0;
    #1;
    n_vec++; if (m_rvalid !== 2'b01) begin n_err++; $display("[TB] FAIL single_rvalid: got %b exp 01", m_rvalid); end
    n_vec++; if (m_rdata[0 +: DW] !== d) begin n_err++; $display("[TB] FAIL single_rdata: got %h exp %h", m_rdata[0 +: DW], d); end
    n_vec++; if (m_err !== 2'b00) begin n_err++; $display("[TB] FAIL single_err: got %b exp 00", m_err); end
    step();
  endtask

  task automatic test_contention();
    logic [1:0] exp_rr [4];
    exp_rr = '{2'b01, 2'b10, 2'b01, 2'b10};
    reset_pulse();
    set_master(0, 1'b1, 1'b0, 32'h8000_0020, 32'h0, 4'hF);
    set_master(1, 1'b1, 1'b0, 32'h8000_0040, 32'h0, 4'hF);
    for (int k = 0; k < 4; k++) begin
      #1;
      n_vec++; if (m_gnt !== exp_rr[k]) begin n_err++; $display("[TB] FAIL contend_rr_gnt[%0d]: got %b exp %b", k, m_gnt, exp_rr[k]); end
      n_vec++; if (fp_m_gnt !== 2'b01) begin n_err++; $display("[TB] FAIL contend_fp_gnt[%0d]: got %b exp 01", k, fp_m_gnt); end
      n_vec++;
      if (s_addr[0 +: AW] !== (exp_rr[k][0] ? 32'h8000_0020 : 32'h8000_0040)) begin
        n_err++; $display("[TB] FAIL contend_saddr[%0d]: got %h", k, s_addr[0 +: AW]);
      end
      if (k > 0) begin
        n_vec++; if (m_rvalid !== exp_rr[k-1]) begin n_err++; $display("[TB] FAIL contend_rvalid[%0d]: got %b exp %b", k, m_rvalid, exp_rr[k-1]); end
      end
      step();
    end
    m_req = '0;
    #1;
    n_vec++; if (m_rvalid !== 2'b10) begin n_err++; $display("[TB] FAIL contend_last_rvalid: got %b exp 10", m_rvalid); end
    step();
  endtask

  task automatic test_parallel();
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom;
    set_master(0, 1'b1, 1'b0, 32'h8000_0100, 32'h0, 4'hF);
    set_master(1, 1'b1, 1'b0, 32'h8001_0200, 32'h0, 4'hF);
    #1;
    n_vec++; if (m_gnt !== 2'b11) begin n_err++; $display("[TB] FAIL parallel_gnt: got %b exp 11", m_gnt); end
    n_vec++; if (s_req !== 3'b011) begin n_err++; $display("[TB] FAIL parallel_sreq: got %b exp 011", s_req); end
    n_vec++; if (s_addr[AW +: AW] !== 32'h8001_0200) begin n_err++; $display("[TB] FAIL parallel_saddr1: got %h exp 80010200", s_addr[AW +: AW]); end
    step();
    m_req = '0;
    s_rdata[0 +: DW]  = a;
    s_rdata[DW +: DW] = b;
    s_err = '0;
    #1;
    n_vec++; if (m_rvalid !== 2'b11) begin n_err++; $display("[TB] FAIL parallel_rvalid: got %b exp 11", m_rvalid); end
    n_vec++; if (m_rdata !== {b, a}) begin n_err++; $display("[TB] FAIL parallel_rdata: got %h exp %h", m_rdata, {b, a}); end
    step();
  endtask

  task automatic test_unmapped();
    set_master(1, 1'b1, 1'b0, 32'h4000_0000, 32'h0, 4'hF);
    #1;
    n_vec++; if (m_gnt !== 2'b10) begin n_err++; $display("[TB] FAIL unmapped_gnt: got %b exp 10", m_gnt); end
    n_vec++; if (s_req !== 3'b000) begin n_err++; $display("[TB] FAIL unmapped_sreq: got %b exp 000", s_req); end
    step();
    m_req = '0;
    s_rdata = {$urandom, $urandom, $urandom};
    s_err = '0;
    #1;
    n_vec++; if (m_rvalid !== 2'b10) begin n_err++; $display("[TB] FAIL unmapped_rvalid: got %b exp 10", m_rvalid); end
    n_vec++; if (m_err !== 2'b10) begin n_err++; $display("[TB] FAIL unmapped_err: got %b exp 10", m_err); end
    n_vec++; if (m_rdata[DW +: DW] !== 32'h0) begin n_err++; $display("[TB] FAIL unmapped_rdata: got %h exp 0", m_rdata[DW +: DW]); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] w, d;
    w = $urandom;
    d = $urandom;
    set_master(0, 1'b1, 1'b1, 32'h8002_0004, w, 4'h3);
    #1;
    n_vec++; if (s_req !== 3'b100 || s_we !== 3'b100) begin n_err++; $display("[TB] FAIL b2b_write_req: got req %b we %b exp 100/100", s_req, s_we); end
    n_vec++; if (s_wdata[2*DW +: DW] !== w || s_be[2*BW +: BW] !== 4'h3) begin n_err++; $display("[TB] FAIL b2b_wdata: got %h/%h exp %h/3", s_wdata[2*DW +: DW], s_be[2*BW +: BW], w); end
    step();
    set_master(0, 1'b1, 1'b0, 32'h8002_0008, 32'h0, 4'hF);
    s_err = 3'b100;
    #1;
    n_vec++; if (m_rvalid[0] !== 1'b1 || m_err[0] !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_write_rsp: got v%b e%b exp v1 e1", m_rvalid[0], m_err[0]); end
    n_vec++; if (m_gnt !== 2'b01 || s_we !== 3'b000) begin n_err++; $display("[TB] FAIL b2b_read_gnt: got gnt %b we %b exp 01/000", m_gnt, s_we); end
    step();
    m_req = '0;
    s_err = '0;
    s_rdata[2*DW +: DW] = d;
    #1;
    n_vec++; if (m_rvalid[0] !== 1'b1 || m_err[0] !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_read_rsp: got v%b e%b exp v1 e0", m_rvalid[0], m_err[0]); end
    n_vec++; if (m_rdata[0 +: DW] !== d) begin n_err++; $display("[TB] FAIL b2b_read_rdata: got %h exp %h", m_rdata[0 +: DW], d); end
    step();
    #1;
    n_vec++; if (m_rvalid !== 2'b00) begin n_err++; $display("[TB] FAIL b2b_idle_rvalid: got %b exp 00", m_rvalid); end
  endtask

  task automatic test_random();
    int          lrg    [NS][NM];
    int          tgt    [NM];
    int          pt     [NM];
    bit          pv_rr  [NM];
    bit          pv_fp  [NM];
    int          win_rr [NS];
    int          win_fp [NS];
    logic [31:0] a      [NM];
    logic [31:0] wd     [NM];
    logic [3:0]  be     [NM];
    bit          we     [NM];
    logic [NM-1:0] eg_rr, eg_fp;
    logic [NS-1:0] es_rr, es_fp;
    int          r;
    for (int s = 0; s < NS; s++)
      for (int m = 0; m < NM; m++) lrg[s][m] = m;
    for (int m = 0; m < NM; m++) begin pv_rr[m] = 0; pv_fp[m] = 0; pt[m] = -2; end
    reset_pulse();
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int m = 0; m < NM; m++) begin
        r = $urandom_range(0, 3);
        if (r < NS) a[m] = 32'h8000_0000 + r * 32'h1_0000 + 32'($urandom_range(0, 'hFFFF));
        else        a[m] = {16'($urandom_range(0, 'h7FFF)), 16'($urandom_range(0, 'hFFFF))};
        wd[m] = $urandom;
        be[m] = 4'($urandom_range(0, 15));
        we[m] = 1'($urandom_range(0, 1));
        set_master(m, 1'($urandom_range(0, 1)), we[m], a[m], wd[m], be[m]);
        tgt[m] = m_req[m] ? ref_decode(a[m]) : -2;
      end
      s_rdata = {$urandom, $urandom, $urandom};
      s_err   = 3'($urandom_range(0, 7));
      #1;
      for (int m = 0; m < NM; m++) begin
        n_vec++; if (m_rvalid[m] !== pv_rr[m] || fp_m_rvalid[m] !== pv_fp[m]) begin n_err++; $display("[TB] FAIL rand_rvalid c%0d m%0d: got %b/%b exp %b/%b", cyc, m, m_rvalid[m], fp_m_rvalid[m], pv_rr[m], pv_fp[m]); end
        if (pv_rr[m]) begin
          n_vec++;
          if (pt[m] < 0 ? (m_err[m] !== 1'b1 || m_rdata[m*DW +: DW] !== 32'h0)
                        : (m_err[m] !== s_err[pt[m]] || m_rdata[m*DW +: DW] !== s_rdata[pt[m]*DW +: DW])) begin
            n_err++; $display("[TB] FAIL rand_rsp c%0d m%0d: got err %b data %h slave %0d", cyc, m, m_err[m], m_rdata[m*DW +: DW], pt[m]);
          end
        end
        if (pv_fp[m]) begin
          n_vec++;
          if (pt[m] < 0 ? (fp_m_err[m] !== 1'b1 || fp_m_rdata[m*DW +: DW] !== 32'h0)
                        : (fp_m_err[m] !== s_err[pt[m]] || fp_m_rdata[m*DW +: DW] !== s_rdata[pt[m]*DW +: DW])) begin
            n_err++; $display("[TB] FAIL rand_fp_rsp c%0d m%0d: got err %b data %h slave %0d", cyc, m, fp_m_err[m], fp_m_rdata[m*DW +: DW], pt[m]);
          end
        end
      end
      for (int s = 0; s < NS; s++) begin
        win_rr[s] = -1;
        win_fp[s] = -1;
        for (int k = 0; k < NM; k++)
          if (win_rr[s] < 0 && tgt[lrg[s][k]] == s) win_rr[s] = lrg[s][k];
        for (int m = 0; m < NM; m++)
          if (win_fp[s] < 0 && tgt[m] == s) win_fp[s] = m;
        es_rr[s] = (win_rr[s] >= 0);
        es_fp[s] = (win_fp[s] >= 0);
      end
      for (int m = 0; m < NM; m++) begin
        eg_rr[m] = (tgt[m] == -1) || (tgt[m] >= 0 && win_rr[tgt[m]] == m);
        eg_fp[m] = (tgt[m] == -1) || (tgt[m] >= 0 && win_fp[tgt[m]] == m);
      end
      n_vec++; if (m_gnt !== eg_rr || s_req !== es_rr) begin n_err++; $display("[TB] FAIL rand_rr_gnt c%0d: got gnt %b sreq %b exp %b %b", cyc, m_gnt, s_req, eg_rr, es_rr); end
      n_vec++; if (fp_m_gnt !== eg_fp || fp_s_req !== es_fp) begin n_err++; $display("[TB] FAIL rand_fp_gnt c%0d: got gnt %b sreq %b exp %b %b", cyc, fp_m_gnt, fp_s_req, eg_fp, es_fp); end
      for (int s = 0; s < NS; s++) begin
        n_vec++;
        if (win_rr[s] >= 0 ? (s_addr[s*AW +: AW] !== a[win_rr[s]] || s_wdata[s*DW +: DW] !== wd[win_rr[s]] ||
                              s_be[s*BW +: BW] !== be[win_rr[s]] || s_we[s] !== we[win_rr[s]])
                           : (s_addr[s*AW +: AW] !== '0 || s_wdata[s*DW +: DW] !== '0 || s_be[s*BW +: BW] !== '0 || s_we[s] !== 1'b0)) begin
          n_err++; $display("[TB] FAIL rand_rr_sbus c%0d s%0d: got addr %h we %b winner %0d", cyc, s, s_addr[s*AW +: AW], s_we[s], win_rr[s]);
        end
        n_vec++;
        if (win_fp[s] >= 0 ? (fp_s_addr[s*AW +: AW] !== a[win_fp[s]] || fp_s_wdata[s*DW +: DW] !== wd[win_fp[s]])
                           : (fp_s_addr[s*AW +: AW] !== '0 || fp_s_wdata[s*DW +: DW] !== '0)) begin
          n_err++; $display("[TB] FAIL rand_fp_sbus c%0d s%0d: got addr %h winner %0d", cyc, s, fp_s_addr[s*AW +: AW], win_fp[s]);
        end
        // Granted master moves to the back of the least-recently-granted order.
        if (win_rr[s] >= 0) begin
          int pos;
          pos = 0;
          for (int k = 0; k < NM; k++) if (lrg[s][k] == win_rr[s]) pos = k;
          for (int k = pos; k < NM - 1; k++) lrg[s][k] = lrg[s][k+1];
          lrg[s][NM-1] = win_rr[s];
        end
      end
      for (int m = 0; m < NM; m++) begin
        pv_rr[m] = eg_rr[m];
        pv_fp[m] = eg_fp[m];
        pt[m]    = tgt[m];
      end
      step();
    end
    m_req = '0;
  endtask

  initial begin
    reset   = 1'b1;
    m_req   = '0;
    m_we    = '0;
    m_be    = '0;
    m_addr  = '0;
    m_wdata = '0;
    s_rdata = '0;
    s_err   = '0;
    @(negedge clk);
    test_reset();
    test_single_read();
    test_contention();
    test_parallel();
    test_unmapped();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
